spmdv_stream_feeder: RTL
========================

// Module: spmdv_stream_feeder
// PURPOSE
//  Host-side transmitter for the SpMDV raw-byte load protocol. Reads a byte image from a sync source memory and
//  answers ld_w_request / raw_data_request with one byte per cycle.
//  Init phase: weights, then indices, then bias. Vector phase: one 16x256 batch per request window.
//  Sits between the bench/host memory and the SpMDV accelerator input ports.
// PARAMETERS
//  INIT_BYTES  24832  weights 12288 + indices 12288 + bias 256, at mem addr 0..INIT_BYTES-1
//  VEC_BYTES   4096   bytes per vector batch (16 vectors x 256)
//  NUM_BATCH   4      batches stored back-to-back from addr INIT_BYTES
//  ADDR_W      16     source memory address width
// PORTS
//  clk               in   1       clock
//  rst               in   1       asynchronous, active-high reset
//  start             in   1       host pulse: begin init sequence
//  start_init        out  1       one-cycle pulse to accelerator
//  ld_w_request      in   1       accelerator requests init bytes
//  raw_data_request  in   1       accelerator requests vector bytes
//  mem_ren           out  1       source memory read enable
//  mem_addr          out  ADDR_W  source memory address
//  mem_q             in   8       read data, valid 1 cycle after mem_ren
//  raw_input         out  8       byte to accelerator
//  w_input_valid     out  1       raw_input carries an init byte
//  raw_data_valid    out  1       raw_input carries a vector byte
//  init_done         out  1       sticky: all INIT_BYTES sent
//  batch_done        out  1       one-cycle pulse after last byte of a batch
//  err               out  1       sticky protocol error
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; batch index 0. rst mid-stream aborts immediately, no flush.
//  States and transitions:
//   IDLE -> START on start.
//   START: start_init=1 for exactly one cycle -> INIT.
//   INIT -> VWAIT when init count reaches INIT_BYTES.
//   VWAIT -> VEC on raw_data_request.
//   VEC -> VWAIT when batch count reaches VEC_BYTES.
//   start is ignored outside IDLE.
//  Latency (fixed, 1 cycle):
//   request high in cycle t with bytes remaining -> mem_ren=1, mem_addr=base+count in t.
//   In t+1: valid=1 (registered) and raw_input=mem_q.
//   Count increments in t, so back-to-back requests give back-to-back bytes.
//  INIT: base 0, drives w_input_valid only.
//   ld_w_request low -> pause: no read, count held, w_input_valid=0 next cycle.
//   Resume continues at the held address.
//  VEC: base INIT_BYTES + batch*VEC_BYTES, drives raw_data_valid only.
//   Byte VEC_BYTES-1 is issued in the cycle after request drops on the last byte, so it still appears in t+1.
//   After the batch: batch_done pulses in the cycle the last byte is valid; batch <= batch+1, wraps NUM_BATCH-1 -> 0.
//  raw_input=0 whenever both valids are 0. w_input_valid and raw_data_valid are never high together.
//  err set (sticky until rst), no byte issued, on:
//   ld_w_request outside START/INIT;
//   raw_data_request in IDLE/START/INIT;
//   ld_w_request and raw_data_request high in the same cycle.
//  init_done rises in the cycle the last init byte is valid.
// STRUCTURE
//  Shared package spmdv_pkg: INIT_BYTES, VEC_BYTES, W_BYTES=12288, BIAS_BYTES=256, state enum encoding.
//  Natural sub-module: spmdv_feed_counter. Loadable up-counter with enable and terminal-count flag.
//   One instance for the init count, one for the vector count.
//  Rest: FSM, address adder, output valid registers.
// TESTING
//  Full init, continuous ld_w_request after start_init:
//   24832 consecutive w_input_valid bytes equal to mem[0..24831]; init_done=1 at the last; err=0.
//  ld_w_request low 3 cycles at byte 100:
//   w_input_valid low 3 cycles; next byte is mem[100], no skip or duplicate.
//  Vector batch 0:
//   raw_data_valid 4096 cycles carrying mem[24832..28927];
//   batch_done pulses with byte 4095; state returns to VWAIT.
//  Five batches with NUM_BATCH=4:
//   5th batch re-reads mem[24832..] (wrap); 4 batch_done pulses before the wrap.
//  raw_data_request asserted in IDLE:
//   err=1, no mem_ren, valids stay 0.
//   rst during INIT at byte 5000: outputs 0 next edge; a fresh start resends from mem[0].
//  Simultaneous ld_w_request and raw_data_request in VWAIT:
//   err=1; neither valid asserted.

Source files
------------

// File: rtl/spmdv_pkg.sv
// Shared constants and state encoding for the SpMDV raw-byte load protocol.
// INIT_BYTES is derived from the three init regions so the layout stays in one place.
package spmdv_pkg;

   localparam int unsigned W_BYTES    = 12288;
   localparam int unsigned IDX_BYTES  = 12288;
   localparam int unsigned BIAS_BYTES = 256;
   localparam int unsigned INIT_BYTES = W_BYTES + IDX_BYTES + BIAS_BYTES;
   localparam int unsigned VEC_BYTES  = 4096;
   localparam int unsigned NUM_BATCH  = 4;
   localparam int unsigned ADDR_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_INIT  = 3'd2,
      ST_VWAIT = 3'd3,
      ST_VEC   = 3'd4
   } feed_state_e;

endpackage

// File: rtl/spmdv_stream_feeder_if.sv
// Host/accelerator/source-memory signals of the stream feeder.
// master = the feeder itself, slave = the host side (memory, accelerator, control).
interface spmdv_stream_feeder_if #(
   parameter int unsigned ADDR_W = spmdv_pkg::ADDR_W
) ();

   logic              start;
   logic              start_init;
   logic              ld_w_request;
   logic              raw_data_request;
   logic              mem_ren;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_q;
   logic [7:0]        raw_input;
   logic              w_input_valid;
   logic              raw_data_valid;
   logic              init_done;
   logic              batch_done;
   logic              err;

   modport master (
      input  start, ld_w_request, raw_data_request, mem_q,
      output start_init, mem_ren, mem_addr, raw_input,
             w_input_valid, raw_data_valid, init_done, batch_done, err
   );

   modport slave (
      output start, ld_w_request, raw_data_request, mem_q,
      input  start_init, mem_ren, mem_addr, raw_input,
             w_input_valid, raw_data_valid, init_done, batch_done, err
   );

endinterface

// File: rtl/spmdv_feed_counter.sv
// Loadable byte counter with enable; saturates at LIMIT and flags it with tc.
// Load has priority over enable.
module spmdv_feed_counter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LIMIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   logic [WIDTH-1:0] count_q, count_d;

   assign count = count_q;
   assign tc    = (count_q == WIDTH'(LIMIT));

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && !tc) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/spmdv_stream_feeder.sv
// Host-side transmitter: streams init bytes then vector batches from a sync source memory
// to the SpMDV accelerator, one byte per request cycle with a fixed one-cycle read latency.
module spmdv_stream_feeder #(
   parameter int unsigned INIT_BYTES = spmdv_pkg::INIT_BYTES,
   parameter int unsigned VEC_BYTES  = spmdv_pkg::VEC_BYTES,
   parameter int unsigned NUM_BATCH  = spmdv_pkg::NUM_BATCH,
   parameter int unsigned ADDR_W     = spmdv_pkg::ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   spmdv_stream_feeder_if.master  bus
);

   import spmdv_pkg::*;

   localparam int unsigned BATCH_W = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;

   feed_state_e        state_q, state_d;
   logic [BATCH_W-1:0] batch_q, batch_d;
   logic               w_valid_q, w_valid_d;
   logic               r_valid_q, r_valid_d;
   logic               init_done_q, init_done_d;
   logic               batch_done_q, batch_done_d;
   logic               err_q, err_d;

   logic [ADDR_W-1:0]  init_cnt, vec_cnt, vec_base;
   logic               init_tc, vec_tc, vec_last;
   logic               init_issue, vec_issue, vec_clr, viol;
   logic               ld, rdr;

   assign ld       = bus.ld_w_request;
   assign rdr      = bus.raw_data_request;
   assign vec_last = (vec_cnt == ADDR_W'(VEC_BYTES - 1));
   assign vec_base = ADDR_W'(INIT_BYTES) + ADDR_W'(batch_q) * ADDR_W'(VEC_BYTES);

   spmdv_feed_counter #(.WIDTH(ADDR_W), .LIMIT(INIT_BYTES)) u_init_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (1'b0),
      .load_val ('0),
      .en       (init_issue),
      .count    (init_cnt),
      .tc       (init_tc)
   );

   spmdv_feed_counter #(.WIDTH(ADDR_W), .LIMIT(VEC_BYTES)) u_vec_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (vec_clr),
      .load_val ('0),
      .en       (vec_issue),
      .count    (vec_cnt),
      .tc       (vec_tc)
   );

   always_comb begin
      state_d      = state_q;
      batch_d      = batch_q;
      init_done_d  = init_done_q;
      batch_done_d = 1'b0;
      init_issue   = 1'b0;
      vec_issue    = 1'b0;
      vec_clr      = 1'b0;
      viol         = ld && rdr;

      unique case (state_q)
         ST_IDLE: begin
            viol = viol | ld | rdr;
            if (bus.start) state_d = ST_START;
         end
         ST_START: begin
            viol       = viol | rdr;
            init_issue = ld && !rdr && !init_tc;
            state_d    = ST_INIT;
         end
         ST_INIT: begin
            viol       = viol | rdr;
            init_issue = ld && !rdr && !init_tc;
            if (init_tc) state_d = ST_VWAIT;
         end
         ST_VWAIT: begin
            viol      = viol | ld;
            vec_issue = rdr && !ld;
            if (vec_issue) state_d = ST_VEC;
         end
         ST_VEC: begin
            viol = viol | ld;
            // The final byte of a batch goes out even if the request has already dropped.
            vec_issue = !ld && !vec_tc && (rdr || vec_last);
            if (vec_tc) begin
               vec_clr = 1'b1;
               state_d = ST_VWAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (init_issue && (init_cnt == ADDR_W'(INIT_BYTES - 1))) init_done_d = 1'b1;
      if (vec_issue && vec_last) begin
         batch_done_d = 1'b1;
         batch_d      = (batch_q == BATCH_W'(NUM_BATCH - 1)) ? '0 : batch_q + BATCH_W'(1);
      end

      w_valid_d = init_issue;
      r_valid_d = vec_issue;
      err_d     = err_q | viol;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         batch_q      <= '0;
         w_valid_q    <= 1'b0;
         r_valid_q    <= 1'b0;
         init_done_q  <= 1'b0;
         batch_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         batch_q      <= batch_d;
         w_valid_q    <= w_valid_d;
         r_valid_q    <= r_valid_d;
         init_done_q  <= init_done_d;
         batch_done_q <= batch_done_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      bus.start_init     = (state_q == ST_START);
      bus.mem_ren        = init_issue | vec_issue;
      bus.mem_addr       = '0;
      if (init_issue)     bus.mem_addr = init_cnt;
      else if (vec_issue) bus.mem_addr = vec_base + vec_cnt;
      bus.raw_input      = (w_valid_q | r_valid_q) ? bus.mem_q : '0;
      bus.w_input_valid  = w_valid_q;
      bus.raw_data_valid = r_valid_q;
      bus.init_done      = init_done_q;
      bus.batch_done     = batch_done_q;
      bus.err            = err_q;
   end

endmodule
